// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NR_PORTS requesters.
// Optional ownership lock is compiled in with `define MEM_ARB_LOCK_EN.
module axi_mem_arbiter #(
  parameter int unsigned NR_PORTS   = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_PORTS-1:0]                req_i,
  input  logic [NR_PORTS-1:0]                we_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NR_PORTS*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]     wdata_i,
  input  logic [NR_PORTS-1:0]                lock_i,
  output logic [NR_PORTS-1:0]                gnt_o,
  output logic [NR_PORTS-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic                found;
  logic [NR_PORTS-1:0] req_eff;
  logic [NR_PORTS-1:0] gnt;
  logic [NR_PORTS-1:0] rvalid_q, rvalid_d;

`ifdef MEM_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  // While locked, everyone but the owner is masked, even when the owner is idle.
  always_comb begin
    req_eff = req_i;
    if (lock_q) begin
      req_eff = req_i & (NR_PORTS'(1) << owner_q);
    end
  end

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (lock_q) begin
      if (!req_i[owner_q] || (found && !lock_i[owner_q])) begin
        lock_d = 1'b0;
      end
    end else if (found && lock_i[win_idx]) begin
      lock_d  = 1'b1;
      owner_d = win_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign req_eff     = req_i;
`endif

  // First requester found scanning upward from rr_q, modulo NR_PORTS.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand = IDX_W'((32'(rr_q) + i) % NR_PORTS);
      if (!found && req_eff[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gnt  = '0;
    rr_d = rr_q;
    if (found) begin
      gnt[win_idx] = 1'b1;
      rr_d = (win_idx == IDX_W'(NR_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // Granted port's payload to the SRAM; zero when nobody is granted.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      if (found && (win_idx == IDX_W'(i))) begin
        mem_we_o    = we_i[i];
        mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_be_o    = be_i[i*BE_W +: BE_W];
        mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rvalid_d = gnt & ~we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      rvalid_q <= '0;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt_o     = gnt;
  assign mem_req_o = found;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Self-checking bench for axi_mem_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin reference model.
module tb_axi_mem_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req, we, lock, gnt, rvalid;
  logic [NP*AW-1:0] addr;
  logic [NP*BW-1:0] be;
  logic [NP*DW-1:0] wdata;
  logic [DW-1:0]    rdata, mem_rdata, mem_wdata;
  logic             mem_req, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [BW-1:0]    mem_be;

  int n_cmp = 0;
  int n_err = 0;
  int m_rr  = 0;

  axi_mem_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .lock_i(lock), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0; lock = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_rr = 0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    mem_rdata = 64'h0;
    #1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
      n_cmp++;
      if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
      n_cmp++;
      if (rvalid !== 3'b000) begin n_err++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
      tick();
    end
    rst_n = 1'b1;
    m_rr = 0;
    tick();
  endtask

  task automatic test_single_read;
    logic [DW-1:0] rd;
    do_reset();
    req[0] = 1'b1;
    addr[0 +: AW] = 32'h40;
    #1;
    n_cmp++;
    if (gnt !== 3'b001) begin n_err++; $display("FAIL read_gnt: got %b expected 001", gnt); end
    n_cmp++;
    if (mem_addr !== 32'h40) begin n_err++; $display("FAIL read_addr: got %h expected 40", mem_addr); end
    n_cmp++;
    if (mem_we !== 1'b0 || mem_req !== 1'b1) begin
      n_err++; $display("FAIL read_ctrl: got we=%b req=%b expected we=0 req=1", mem_we, mem_req);
    end
    tick();
    clear_inputs();
    rd = {$urandom(), $urandom()};
    mem_rdata = rd;
    #1;
    n_cmp++;
    if (rvalid !== 3'b001) begin n_err++; $display("FAIL read_rvalid: got %b expected 001", rvalid); end
    n_cmp++;
    if (rdata !== rd) begin n_err++; $display("FAIL read_rdata: got %h expected %h", rdata, rd); end
    tick();
    n_cmp++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL read_rvalid_once: got %b expected 000", rvalid); end
  endtask

  task automatic test_round_robin;
    logic [NP-1:0] seq [4];
    seq = '{3'b001, 3'b010, 3'b001, 3'b010};
    do_reset();
    req = 3'b011;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (gnt !== seq[c]) begin n_err++; $display("FAIL rr_seq%0d: got %b expected %b", c, gnt, seq[c]); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_write;
    do_reset();
    req = 3'b010;
    we = 3'b010;
    be[BW +: BW] = 8'hF0;
    wdata[DW +: DW] = 64'hDEAD;
    addr[AW +: AW] = 32'h1234;
    #1;
    n_cmp++;
    if (gnt !== 3'b010) begin n_err++; $display("FAIL wr_gnt: got %b expected 010", gnt); end
    n_cmp++;
    if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b expected 1", mem_we); end
    n_cmp++;
    if (mem_be !== 8'hF0) begin n_err++; $display("FAIL wr_be: got %h expected f0", mem_be); end
    n_cmp++;
    if (mem_wdata !== 64'hDEAD) begin n_err++; $display("FAIL wr_data: got %h expected dead", mem_wdata); end
    n_cmp++;
    if (mem_addr !== 32'h1234) begin n_err++; $display("FAIL wr_addr: got %h expected 1234", mem_addr); end
    tick();
    clear_inputs();
    #1;
    n_cmp++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL wr_rvalid: got %b expected 000", rvalid); end
  endtask

  task automatic test_wrap;
    do_reset();
    req = 3'b010;
    #1;
    n_cmp++;
    if (gnt !== 3'b010) begin n_err++; $display("FAIL wrap_first: got %b expected 010", gnt); end
    tick();
    req = 3'b011;
    #1;
    n_cmp++;
    if (gnt !== 3'b001) begin n_err++; $display("FAIL wrap_port0: got %b expected 001", gnt); end
    tick();
    #1;
    n_cmp++;
    if (gnt !== 3'b010) begin n_err++; $display("FAIL wrap_rr1: got %b expected 010", gnt); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    req = 3'b001;
    #1;
    n_cmp++;
    if (gnt !== 3'b001) begin n_err++; $display("FAIL mid_gnt: got %b expected 001", gnt); end
    rst_n = 1'b0;
    clear_inputs();
    tick();
    n_cmp++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL mid_rvalid_rst: got %b expected 000", rvalid); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (rvalid !== 3'b000) begin n_err++; $display("FAIL mid_rvalid_after: got %b expected 000", rvalid); end
    m_rr = 0;
  endtask

  task automatic test_lock;
    logic [NP-1:0] exp_seq [4];
    logic [NP-1:0] req_seq [4];
    logic [NP-1:0] lock_seq [4];
`ifdef MEM_ARB_LOCK_EN
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b010};
    req_seq = '{3'b011, 3'b011, 3'b011, 3'b010};
    lock_seq = '{3'b001, 3'b001, 3'b000, 3'b000};
`else
    exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
    req_seq = '{3'b011, 3'b011, 3'b011, 3'b011};
    lock_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req = req_seq[c];
      lock = lock_seq[c];
      #1;
      n_cmp++;
      if (gnt !== exp_seq[c]) begin n_err++; $display("FAIL lock_seq%0d: got %b expected %b", c, gnt, exp_seq[c]); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random;
    bit            pend [NP];
    bit            p_we [NP];
    logic [AW-1:0] p_addr [NP];
    logic [BW-1:0] p_be [NP];
    logic [DW-1:0] p_data [NP];
    int            p_wait [NP];
    logic [NP-1:0] eg, erv;
    logic [DW-1:0] rd;
    int            w;
    for (int p = 0; p < NP; p++) begin pend[p] = 0; p_wait[p] = 0; end
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1; p_wait[p] = 0;
          p_we[p] = 1'($urandom_range(0, 1));
          p_addr[p] = $urandom();
          p_be[p] = 8'($urandom());
          p_data[p] = {$urandom(), $urandom()};
        end
        req[p] = pend[p];
        we[p] = p_we[p];
        addr[p*AW +: AW] = p_addr[p];
        be[p*BW +: BW] = p_be[p];
        wdata[p*DW +: DW] = p_data[p];
      end
      rd = {$urandom(), $urandom()};
      mem_rdata = rd;
      w = -1;
      for (int i = 0; i < NP; i++) begin
        if (w < 0 && pend[(m_rr + i) % NP]) w = (m_rr + i) % NP;
      end
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== eg) begin n_err++; $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, gnt, eg); end
      n_cmp++;
      if (mem_req !== (w >= 0)) begin n_err++; $display("FAIL rnd_mem_req c%0d: got %b", cyc, mem_req); end
      n_cmp++;
      if (rdata !== rd) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h expected %h", cyc, rdata, rd); end
      if (w >= 0) begin
        n_cmp++;
        if (mem_we !== p_we[w] || mem_addr !== p_addr[w] || mem_be !== p_be[w] || mem_wdata !== p_data[w]) begin
          n_err++;
          $display("FAIL rnd_payload c%0d: got we=%b a=%h be=%h d=%h expected we=%b a=%h be=%h d=%h", cyc,
                   mem_we, mem_addr, mem_be, mem_wdata, p_we[w], p_addr[w], p_be[w], p_data[w]);
        end
        n_cmp++;
        if (p_wait[w] > NP - 1) begin n_err++; $display("FAIL rnd_wait c%0d: got %0d expected <=%0d", cyc, p_wait[w], NP - 1); end
      end else begin
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_be !== '0 || mem_wdata !== '0) begin
          n_err++; $display("FAIL rnd_idle c%0d: got we=%b a=%h be=%h d=%h expected zeros", cyc, mem_we, mem_addr, mem_be, mem_wdata);
        end
      end
      erv = '0;
      for (int p = 0; p < NP; p++) if (pend[p] && p != w) p_wait[p]++;
      if (w >= 0) begin
        pend[w] = 0;
        if (!p_we[w]) erv[w] = 1'b1;
        m_rr = (w + 1) % NP;
      end
      tick();
      n_cmp++;
      if (rvalid !== erv) begin n_err++; $display("FAIL rnd_rvalid c%0d: got %b expected %b", cyc, rvalid, erv); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_wrap();
    test_lock();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
